// File: rtl/simmem_pkg.sv
// Shared types and timing constants for the simulated-memory write path.
// Costs are in clock cycles; DelayWidth must hold the largest cost minus one.
package simmem_pkg;

    localparam int unsigned AxAddrWidth            = 16;
    localparam int unsigned RowBufferLenWidth      = 8;
    localparam int unsigned IdWidth                = 4;
    localparam int unsigned WriteRespBankAddrWidth = 4;

    localparam int unsigned DelayWidth     = 8;
    localparam int unsigned RowHitCost     = 10;
    localparam int unsigned PrechargeCost  = 50;
    localparam int unsigned ActivationCost = 45;

    typedef logic [IdWidth-1:0]                          axi_id_t;
    typedef logic [WriteRespBankAddrWidth-1:0]           write_iid_t;
    typedef logic [AxAddrWidth-RowBufferLenWidth-1:0]    row_id_t;

    typedef struct packed {
        axi_id_t                id;
        logic [AxAddrWidth-1:0] addr;
        logic [7:0]             burst_len;
        logic [2:0]             burst_size;
        logic [1:0]             burst_type;
    } waddr_t;

    function automatic row_id_t row_of(input logic [AxAddrWidth-1:0] addr);
        return addr[AxAddrWidth-1:RowBufferLenWidth];
    endfunction

endpackage

// File: rtl/simmem_req_fifo.sv
// Pending-request FIFO: registered output, push and pop may coincide.
// Callers must not push when full or pop when empty.
module simmem_req_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;

    assign full_o  = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/simmem_wdelay_calc.sv
// Single-bank write-delay model: requests are served in acceptance order with
// precharge/activate/access costs depending on the open-row state.
module simmem_wdelay_calc
    import simmem_pkg::*;
#(
    parameter int unsigned FifoDepth = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  waddr_t                            waddr_i,
    input  logic [WriteRespBankAddrWidth-1:0] waddr_iid_i,
    input  logic                              waddr_valid_i,
    output logic                              waddr_ready_o,
    output logic                              release_valid_o,
    output logic [WriteRespBankAddrWidth-1:0] release_iid_o
);

    typedef enum logic [1:0] {IDLE, PRECHARGE, ACTIVATE, ACCESS} state_e;

    typedef struct packed {
        row_id_t    row;
        write_iid_t iid;
    } req_t;

    localparam logic [DelayWidth-1:0] HitLoad = DelayWidth'(RowHitCost - 1);
    localparam logic [DelayWidth-1:0] PreLoad = DelayWidth'(PrechargeCost - 1);
    localparam logic [DelayWidth-1:0] ActLoad = DelayWidth'(ActivationCost - 1);

    state_e                state_q, state_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;
    row_id_t               open_row_q, open_row_d;
    logic                  open_valid_q, open_valid_d;
    req_t                  cur_q, cur_d;
    write_iid_t            last_iid_q;

    req_t fifo_in, head;
    logic fifo_full, fifo_empty, push, pop;

    // Only the row bits of the address matter to the bank model.
    logic unused_fields;
    assign unused_fields = ^{waddr_i.id, waddr_i.addr[RowBufferLenWidth-1:0],
                             waddr_i.burst_len, waddr_i.burst_size, waddr_i.burst_type};

    assign fifo_in       = '{row: row_of(waddr_i.addr), iid: waddr_iid_i};
    assign waddr_ready_o = ~fifo_full;
    assign push          = waddr_valid_i & ~fifo_full;
    assign pop           = (state_q == IDLE) & ~fifo_empty;

    simmem_req_fifo #(
        .Depth (FifoDepth),
        .Width ($bits(req_t))
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        open_row_d      = open_row_q;
        open_valid_d    = open_valid_q;
        cur_d           = cur_q;
        release_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cur_d = head;
                    if (open_valid_q && (open_row_q == head.row)) begin
                        state_d = ACCESS;
                        cnt_d   = HitLoad;
                    end else if (!open_valid_q) begin
                        state_d = ACTIVATE;
                        cnt_d   = ActLoad;
                    end else begin
                        state_d = PRECHARGE;
                        cnt_d   = PreLoad;
                    end
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    open_valid_d = 1'b0;
                    state_d      = ACTIVATE;
                    cnt_d        = ActLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACTIVATE: begin
                if (cnt_q == '0) begin
                    open_row_d   = cur_q.row;
                    open_valid_d = 1'b1;
                    state_d      = ACCESS;
                    cnt_d        = HitLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    release_valid_o = 1'b1;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cur_q changes at the next pop, so the idle-time iid comes from last_iid_q.
    assign release_iid_o = release_valid_o ? cur_q.iid : last_iid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            open_row_q   <= '0;
            open_valid_q <= 1'b0;
            cur_q        <= '0;
            last_iid_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            open_row_q   <= open_row_d;
            open_valid_q <= open_valid_d;
            cur_q        <= cur_d;
            if (release_valid_o) last_iid_q <= cur_q.iid;
        end
    end

endmodule

// File: tb/tb_simmem_wdelay_calc.sv
// Directed bench for simmem_wdelay_calc: expected release iid and cycle are
// queued at acceptance and checked by an independent release monitor.
module tb_simmem_wdelay_calc;
    import simmem_pkg::*;

    localparam int W = WriteRespBankAddrWidth + 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    waddr_t     waddr_v = '0;
    logic [3:0] iid_v = '0;
    logic       valid_v = 1'b0;
    logic       ready;
    logic       rel_valid;
    logic [3:0] rel_iid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [3:0] last_iid = '0;
    logic [W-1:0] exp_q[$];

    simmem_wdelay_calc #(.FifoDepth(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .waddr_i         (waddr_v),
        .waddr_iid_i     (iid_v),
        .waddr_valid_i   (valid_v),
        .waddr_ready_o   (ready),
        .release_valid_o (rel_valid),
        .release_iid_o   (rel_iid)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: every release must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rel_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_release: iid %0d at cycle %0d, none expected", rel_iid, cyc);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (rel_iid !== e[W-1:32] || cyc !== int'(e[31:0])) begin
                        failures++;
                        $display("FAIL release: iid %0d at cycle %0d, expected iid %0d at cycle %0d",
                                 rel_iid, cyc, e[W-1:32], e[31:0]);
                    end
                    last_iid = e[W-1:32];
                end
            end else begin
                checks++;
                if (rel_iid !== last_iid) begin
                    failures++;
                    $display("FAIL iid_hold: got %0d expected %0d at cycle %0d", rel_iid, last_iid, cyc);
                end
            end
        end
    end

    // called just after a negedge; asserts and releases reset within the low phase
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        valid_v = 1'b0;
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_rel_valid", int'(rel_valid), 0);
        check("reset_rel_iid", int'(rel_iid), 0);
        last_iid = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send(input logic [15:0] addr, input logic [3:0] iid,
                        output int t, output logic first_ready);
        int n;
        waddr_v      = '0;
        waddr_v.addr = addr;
        waddr_v.id   = 4'hA;
        iid_v        = iid;
        valid_v      = 1'b1;
        first_ready  = ready;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: iid %0d not accepted in 200 cycles", iid);
        end
        @(negedge clk);
        valid_v = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] iid, input int at);
        exp_q.push_back({iid, 32'(at)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d releases outstanding", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t, c0;
        logic fr;
        int acc_off[6] = '{0, 1, 2, 3, 4, 58};
        int rel_off[6] = '{56, 67, 78, 89, 100, 111};

        @(negedge clk);
        apply_reset();

        // closed row, then hit, then conflict
        send(16'h0100, 4'd3, t, fr);
        check("first_accept_ready", int'(fr), 1);
        push_exp(4'd3, t + 56);
        drain();
        send(16'h01FF, 4'd4, t, fr);
        push_exp(4'd4, t + 11);
        drain();
        send(16'h0200, 4'd5, t, fr);
        push_exp(4'd5, t + 106);
        drain();

        // back-to-back fill: FIFO full on the sixth request
        apply_reset();
        c0 = 0;
        for (int k = 0; k < 6; k++) begin
            send(16'h0500, 4'(k), t, fr);
            if (k == 0) c0 = t;
            check($sformatf("fill_ready_%0d", k), int'(fr), (k < 5) ? 1 : 0);
            check($sformatf("fill_accept_cycle_%0d", k), t - c0, acc_off[k]);
            push_exp(4'(k), c0 + rel_off[k]);
        end
        drain();

        // reset during ACTIVATE discards the request and closes the row
        send(16'h0300, 4'd7, t, fr);
        repeat (20) @(negedge clk);
        apply_reset();
        send(16'h0300, 4'd8, t, fr);
        check("post_reset_accept_ready", int'(fr), 1);
        push_exp(4'd8, t + 56);
        drain();
        repeat (60) @(negedge clk);

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
